// File: rtl/regbank_rw.sv
`default_nettype none
// ============================================================================
// Module      : regbank_rw
// Description : Parametrised register bank of NUM_GP general registers plus
//               FP and SP. Two combinational read ports, one byte-enabled
//               write port with optional same-cycle bypass, a per-register
//               busy scoreboard and a dedicated SP push/pop adjust path.
// Revision    : 1.0 - initial release
// ============================================================================
module regbank_rw #(
    parameter int               XLEN              = 64,
    parameter int               NUM_GP            = 16,
    parameter logic [XLEN-1:0]  GP_RESET_VALUE    = '1,
    parameter logic [XLEN-1:0]  STACK_RESET_VALUE = '0,
    parameter bit               BYPASS            = 1'b1,
    parameter int               IDX_W             = $clog2(NUM_GP + 2)
) (
    input  logic                clk,
    input  logic                reset,

    input  logic [IDX_W-1:0]    rd_addr_a,
    output logic [XLEN-1:0]     rd_data_a,
    output logic                rd_busy_a,

    input  logic [IDX_W-1:0]    rd_addr_b,
    output logic [XLEN-1:0]     rd_data_b,
    output logic                rd_busy_b,

    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic [XLEN/8-1:0]   wr_be,

    input  logic                sb_set_en,
    input  logic [IDX_W-1:0]    sb_set_addr,

    input  logic                sp_adj_en,
    input  logic                sp_adj_dec,
    input  logic [7:0]          sp_adj_amt,

    output logic [XLEN-1:0]     fp_out,
    output logic [XLEN-1:0]     sp_out,
    output logic                sp_conflict,
    output logic                err_oob
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               c_NUM_REGS = NUM_GP + 2;
    localparam int               c_BYTES    = XLEN / 8;
    localparam int               c_FP_POS   = NUM_GP;
    localparam int               c_SP_POS   = NUM_GP + 1;
    localparam logic [IDX_W-1:0] c_SP_IDX   = IDX_W'(c_SP_POS);
    // One adjust unit is one register-width of bytes.
    localparam logic [XLEN-1:0]  c_SP_STEP  = XLEN'(c_BYTES);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]        r_regs [c_NUM_REGS];
    logic [c_NUM_REGS-1:0]  r_busy;
    logic                   r_err_oob;
    logic                   r_sp_conflict;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [XLEN-1:0]        w_be_mask;
    logic                   w_rd_ok_a;
    logic                   w_rd_ok_b;
    logic                   w_wr_ok;
    logic                   w_set_ok;
    logic                   w_wr_sp;
    logic [XLEN-1:0]        w_rd_raw_a;
    logic [XLEN-1:0]        w_rd_raw_b;
    logic                   w_busy_raw_a;
    logic                   w_busy_raw_b;
    logic [XLEN-1:0]        w_wr_old;
    logic [XLEN-1:0]        w_wr_merged;
    logic                   w_byp_a;
    logic                   w_byp_b;
    logic [XLEN-1:0]        w_sp_delta;
    logic [XLEN-1:0]        w_sp_adjusted;
    logic                   w_sp_conflict_next;
    logic                   w_oob_event;

    // Expand byte enables into a bit mask.
    for (genvar gi = 0; gi < c_BYTES; gi++) begin : g_be_mask
        assign w_be_mask[8*gi +: 8] = {8{wr_be[gi]}};
    end

    // Index range qualification; anything above SP is out of range.
    assign w_rd_ok_a = (rd_addr_a <= c_SP_IDX);
    assign w_rd_ok_b = (rd_addr_b <= c_SP_IDX);
    assign w_wr_ok   = wr_en     && (wr_addr     <= c_SP_IDX);
    assign w_set_ok  = sb_set_en && (sb_set_addr <= c_SP_IDX);
    assign w_wr_sp   = w_wr_ok   && (wr_addr == c_SP_IDX);

    // Register selection for both read ports and the write read-modify path.
    // An index with no matching entry yields zero data and a clear busy bit.
    always_comb begin
        w_rd_raw_a   = '0;
        w_rd_raw_b   = '0;
        w_busy_raw_a = 1'b0;
        w_busy_raw_b = 1'b0;
        w_wr_old     = '0;
        for (int i = 0; i < c_NUM_REGS; i++) begin
            if (rd_addr_a == IDX_W'(i)) begin
                w_rd_raw_a   = r_regs[i];
                w_busy_raw_a = r_busy[i];
            end
            if (rd_addr_b == IDX_W'(i)) begin
                w_rd_raw_b   = r_regs[i];
                w_busy_raw_b = r_busy[i];
            end
            if (wr_addr == IDX_W'(i)) begin
                w_wr_old = r_regs[i];
            end
        end
    end

    // Post-edge value of the write target: enabled bytes replaced.
    assign w_wr_merged = (w_wr_old & ~w_be_mask) | (wr_data & w_be_mask);

    // Bypass only ever forwards write data, never an SP adjust. Equality
    // with an in-range write address already implies the read is in range.
    assign w_byp_a = BYPASS && w_wr_ok && (wr_addr == rd_addr_a);
    assign w_byp_b = BYPASS && w_wr_ok && (wr_addr == rd_addr_b);

    assign rd_data_a = w_byp_a ? w_wr_merged : w_rd_raw_a;
    assign rd_data_b = w_byp_b ? w_wr_merged : w_rd_raw_b;
    // Busy always reflects the pre-edge scoreboard.
    assign rd_busy_a = w_busy_raw_a;
    assign rd_busy_b = w_busy_raw_b;

    // SP adjust arithmetic wraps modulo 2^XLEN in both directions.
    assign w_sp_delta    = XLEN'(sp_adj_amt) * c_SP_STEP;
    assign w_sp_adjusted = sp_adj_dec ? (r_regs[c_SP_POS] - w_sp_delta)
                                      : (r_regs[c_SP_POS] + w_sp_delta);

    // A write to SP overrides a concurrent adjust, which is then reported.
    assign w_sp_conflict_next = w_wr_sp && sp_adj_en;

    // Any out-of-range index; read ports count regardless of enables.
    assign w_oob_event = !w_rd_ok_a || !w_rd_ok_b
                       || (wr_en     && !w_wr_ok)
                       || (sb_set_en && !w_set_ok);

    // Register array: byte-enabled write, with SP otherwise following adjust.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= (i < NUM_GP) ? GP_RESET_VALUE : STACK_RESET_VALUE;
            end
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                if (w_wr_ok && (wr_addr == IDX_W'(i))) begin
                    r_regs[i] <= w_wr_merged;
                end else if ((i == c_SP_POS) && sp_adj_en) begin
                    r_regs[i] <= w_sp_adjusted;
                end
            end
        end
    end

    // Busy scoreboard: set from decode takes priority over clear from writeback.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= '0;
        end else begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                if (w_set_ok && (sb_set_addr == IDX_W'(i))) begin
                    r_busy[i] <= 1'b1;
                end else if (w_wr_ok && (wr_addr == IDX_W'(i))) begin
                    r_busy[i] <= 1'b0;
                end
            end
        end
    end

    // Status flags: sticky out-of-range error and one-cycle SP conflict pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_oob     <= 1'b0;
            r_sp_conflict <= 1'b0;
        end else begin
            r_err_oob     <= r_err_oob | w_oob_event;
            r_sp_conflict <= w_sp_conflict_next;
        end
    end

    assign fp_out      = r_regs[c_FP_POS];
    assign sp_out      = r_regs[c_SP_POS];
    assign sp_conflict = r_sp_conflict;
    assign err_oob     = r_err_oob;

endmodule
`default_nettype wire

// File: tb/tb_regbank_rw.sv
`default_nettype none
// ============================================================================
// Module      : tb_regbank_rw
// Description : Self-checking bench for regbank_rw (XLEN=64, NUM_GP=16):
//               directed scenarios followed by random traffic, compared to a
//               behavioural array model of the register bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_rw;

    localparam int NG = 16;
    localparam int NR = NG + 2;

    logic        clk;
    logic        reset;
    logic [4:0]  rd_addr_a;
    logic [63:0] rd_data_a;
    logic        rd_busy_a;
    logic [4:0]  rd_addr_b;
    logic [63:0] rd_data_b;
    logic        rd_busy_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic        sb_set_en;
    logic [4:0]  sb_set_addr;
    logic        sp_adj_en;
    logic        sp_adj_dec;
    logic [7:0]  sp_adj_amt;
    logic [63:0] fp_out;
    logic [63:0] sp_out;
    logic        sp_conflict;
    logic        err_oob;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [63:0] m_regs [0:NR-1];
    bit          m_busy [0:NR-1];
    bit          m_err;
    bit          m_conf;

    regbank_rw #(
        .XLEN   (64),
        .NUM_GP (NG),
        .BYPASS (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr_a   (rd_addr_a),
        .rd_data_a   (rd_data_a),
        .rd_busy_a   (rd_busy_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_b   (rd_data_b),
        .rd_busy_b   (rd_busy_b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .sb_set_en   (sb_set_en),
        .sb_set_addr (sb_set_addr),
        .sp_adj_en   (sp_adj_en),
        .sp_adj_dec  (sp_adj_dec),
        .sp_adj_amt  (sp_adj_amt),
        .fp_out      (fp_out),
        .sp_out      (sp_out),
        .sp_conflict (sp_conflict),
        .err_oob     (err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int k = 0; k < 8; k++) begin
            if (be[k]) r[8*k +: 8] = d[8*k +: 8];
        end
        return r;
    endfunction

    function automatic logic [63:0] exp_rd(input logic [4:0] a);
        if (int'(a) >= NR) return 64'd0;
        if (wr_en && wr_addr == a) return merge(m_regs[a], wr_data, wr_be);
        return m_regs[a];
    endfunction

    function automatic logic [63:0] exp_busy(input logic [4:0] a);
        if (int'(a) >= NR) return 64'd0;
        return {63'd0, m_busy[a]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = (i < NG) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd0;
            m_busy[i] = 1'b0;
        end
        m_err  = 1'b0;
        m_conf = 1'b0;
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0; wr_be = 0;
        sb_set_en = 0; sb_set_addr = 0;
        sp_adj_en = 0; sp_adj_dec = 0; sp_adj_amt = 0;
    endtask

    // One clock cycle: check reads mid-cycle, advance model across the edge,
    // then check registered outputs just after the edge.
    task automatic step();
        logic [63:0] n_regs [0:NR-1];
        bit          n_busy [0:NR-1];
        bit          n_conf;
        bit          n_err;
        bit          wr_sp;
        @(negedge clk);
        chk("rd_data_a", rd_data_a, exp_rd(rd_addr_a));
        chk("rd_busy_a", {63'd0, rd_busy_a}, exp_busy(rd_addr_a));
        chk("rd_data_b", rd_data_b, exp_rd(rd_addr_b));
        chk("rd_busy_b", {63'd0, rd_busy_b}, exp_busy(rd_addr_b));
        n_regs = m_regs;
        n_busy = m_busy;
        n_conf = 1'b0;
        n_err  = m_err;
        wr_sp  = wr_en && (int'(wr_addr) == NR - 1);
        if (wr_en && int'(wr_addr) < NR) begin
            n_regs[wr_addr] = merge(m_regs[wr_addr], wr_data, wr_be);
            n_busy[wr_addr] = 1'b0;
        end
        if (sp_adj_en) begin
            if (wr_sp) n_conf = 1'b1;
            else if (sp_adj_dec) n_regs[NR-1] = m_regs[NR-1] - 64'(sp_adj_amt) * 64'd8;
            else                 n_regs[NR-1] = m_regs[NR-1] + 64'(sp_adj_amt) * 64'd8;
        end
        if (sb_set_en && int'(sb_set_addr) < NR) n_busy[sb_set_addr] = 1'b1;
        if ((wr_en && int'(wr_addr) >= NR) || (sb_set_en && int'(sb_set_addr) >= NR)
            || int'(rd_addr_a) >= NR || int'(rd_addr_b) >= NR)
            n_err = 1'b1;
        @(posedge clk);
        #1;
        m_regs = n_regs;
        m_busy = n_busy;
        m_conf = n_conf;
        m_err  = n_err;
        chk("fp_out", fp_out, m_regs[NR-2]);
        chk("sp_out", sp_out, m_regs[NR-1]);
        chk("sp_conflict", {63'd0, sp_conflict}, {63'd0, m_conf});
        chk("err_oob", {63'd0, err_oob}, {63'd0, m_err});
    endtask

    initial begin
        idle();
        rd_addr_a = 0;
        rd_addr_b = 0;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: read every index on both ports.
        chk("rst_sp", sp_out, 64'd0);
        chk("rst_fp", fp_out, 64'd0);
        chk("rst_err", {63'd0, err_oob}, 64'd0);
        for (int i = 0; i < NR; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(NR - 1 - i);
            step();
        end

        // Byte-enabled write to g3 with bypass on port A.
        rd_addr_a = 5'd3; rd_addr_b = 5'd4;
        wr_en = 1; wr_addr = 5'd3; wr_data = 64'h1122_3344_5566_7788; wr_be = 8'h0F;
        #1;
        chk("byp_g3", rd_data_a, 64'hFFFF_FFFF_5566_7788);
        step();
        idle();
        #1;
        chk("arr_g3", rd_data_a, 64'hFFFF_FFFF_5566_7788);
        step();

        // Scoreboard: set, set+clear same cycle, clear alone.
        rd_addr_a = 5'd5;
        sb_set_en = 1; sb_set_addr = 5'd5;
        step();
        chk("busy_g5_set", {63'd0, rd_busy_a}, 64'd1);
        wr_en = 1; wr_addr = 5'd5; wr_data = 64'hABCD; wr_be = 8'hFF;
        step();
        chk("busy_g5_setwins", {63'd0, rd_busy_a}, 64'd1);
        sb_set_en = 0; wr_be = 8'h00;
        step();
        chk("busy_g5_clr", {63'd0, rd_busy_a}, 64'd0);
        idle();

        // SP push wrap then pop back.
        sp_adj_en = 1; sp_adj_dec = 1; sp_adj_amt = 8'd2;
        step();
        chk("sp_push_wrap", sp_out, 64'hFFFF_FFFF_FFFF_FFF0);
        sp_adj_dec = 0;
        step();
        chk("sp_pop_wrap", sp_out, 64'd0);

        // Write to SP with concurrent adjust: write wins, one-cycle pulse.
        rd_addr_a = 5'(NR - 1);
        wr_en = 1; wr_addr = 5'(NR - 1); wr_data = 64'h1000; wr_be = 8'hFF;
        sp_adj_en = 1; sp_adj_dec = 0; sp_adj_amt = 8'd1;
        step();
        chk("sp_conf_val", sp_out, 64'h1000);
        chk("sp_conf_pulse", {63'd0, sp_conflict}, 64'd1);
        idle();
        step();
        chk("sp_conf_end", {63'd0, sp_conflict}, 64'd0);

        // Random traffic, all indices in range.
        for (int n = 0; n < 300; n++) begin
            wr_en       = 1'($urandom_range(0, 1));
            wr_addr     = 5'($urandom_range(0, NR - 1));
            wr_data     = {$urandom, $urandom};
            wr_be       = 8'($urandom);
            sb_set_en   = 1'($urandom_range(0, 1));
            sb_set_addr = 5'($urandom_range(0, NR - 1));
            sp_adj_en   = 1'($urandom_range(0, 1));
            sp_adj_dec  = 1'($urandom_range(0, 1));
            sp_adj_amt  = 8'($urandom);
            rd_addr_a   = ($urandom_range(0, 1) == 1) ? wr_addr : 5'($urandom_range(0, NR - 1));
            rd_addr_b   = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, NR - 1));
            if ($urandom_range(0, 7) == 0) wr_addr = 5'(NR - 1);
            step();
        end
        chk("err_clean_inrange", {63'd0, err_oob}, 64'd0);

        // Out-of-range read on port B.
        idle();
        rd_addr_a = 5'd0; rd_addr_b = 5'd20;
        #1;
        chk("oob_rd_data", rd_data_b, 64'd0);
        chk("oob_rd_busy", {63'd0, rd_busy_b}, 64'd0);
        step();
        chk("oob_err_set", {63'd0, err_oob}, 64'd1);
        rd_addr_b = 5'd1;
        step();
        chk("oob_err_hold", {63'd0, err_oob}, 64'd1);

        // Random traffic including out-of-range indices.
        for (int n = 0; n < 100; n++) begin
            wr_en       = 1'($urandom_range(0, 1));
            wr_addr     = 5'($urandom_range(0, 31));
            wr_data     = {$urandom, $urandom};
            wr_be       = 8'($urandom);
            sb_set_en   = 1'($urandom_range(0, 1));
            sb_set_addr = 5'($urandom_range(0, 31));
            sp_adj_en   = 1'($urandom_range(0, 1));
            sp_adj_dec  = 1'($urandom_range(0, 1));
            sp_adj_amt  = 8'($urandom);
            rd_addr_a   = 5'($urandom_range(0, 31));
            rd_addr_b   = 5'($urandom_range(0, 31));
            step();
        end

        // Asynchronous reset asserted mid-cycle, with a write pending.
        idle();
        rd_addr_a = 5'd3; rd_addr_b = 5'd5;
        sb_set_en = 1; sb_set_addr = 5'd5;
        sp_adj_en = 1; sp_adj_amt = 8'd4;
        #2;
        reset = 1'b1;
        #1;
        chk("arst_err", {63'd0, err_oob}, 64'd0);
        chk("arst_sp", sp_out, 64'd0);
        chk("arst_fp", fp_out, 64'd0);
        chk("arst_g3", rd_data_a, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("arst_busy5", {63'd0, rd_busy_b}, 64'd0);
        @(posedge clk);
        #1;
        chk("arst_hold_sp", sp_out, 64'd0);
        reset = 1'b0;
        idle();
        model_reset();
        for (int i = 0; i < NR; i++) begin
            rd_addr_a = 5'(i);
            rd_addr_b = 5'(NR - 1 - i);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
